ex_mem_stage: RTL and testbench

- Execute stage plus EX/MEM pipeline register of the 16-bit, 8-register MIPS pipeline.
- Consumes the ID/EX register outputs and resolves data hazards by forwarding from EX/MEM and MEM/WB.
- Computes the 16-bit ALU result and registers result, store data and control for the memory stage.
- Load-use hazards are not handled here; the upstream stall logic inserts a bubble for them.

---
 rtl/ex_mem_stage_if.sv | 50 +++++
 rtl/ex_mem_stage.sv | 159 +++++++++++++++
 tb/tb_ex_mem_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// ID/EX, MEM/WB and EX/MEM signal bundle for the execute stage.
// master drives the pipeline inputs; slave (the stage) drives the registered outputs.
interface ex_mem_stage_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 3
);
  logic [3:0]    aluSig_in;
  logic          WB_in;
  logic          WMEM_in;
  logic          load_in;
  logic          extendForMem_in;
  logic [DW-1:0] R1_in;
  logic [DW-1:0] R2_in;
  logic [DW-1:0] wdMem_in;
  logic [RW-1:0] rd_in;
  logic [RW-1:0] rs_in;
  logic [RW-1:0] rt_in;
  logic          b_from_rt;
  logic          hold;
  logic          flush;
  logic          wb_we;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  logic [DW-1:0] alu_out;
  logic [DW-1:0] wdMem_out;
  logic [RW-1:0] rd_out;
  logic          WB_out;
  logic          WMEM_out;
  logic          load_out;
  logic          extendForMem_out;
  logic          zero_out;
  logic          ovf_sticky;

  modport master (
    output aluSig_in, WB_in, WMEM_in, load_in, extendForMem_in,
           R1_in, R2_in, wdMem_in, rd_in, rs_in, rt_in, b_from_rt,
           hold, flush, wb_we, wb_rd, wb_data,
    input  alu_out, wdMem_out, rd_out, WB_out, WMEM_out, load_out,
           extendForMem_out, zero_out, ovf_sticky
  );

  modport slave (
    input  aluSig_in, WB_in, WMEM_in, load_in, extendForMem_in,
           R1_in, R2_in, wdMem_in, rd_in, rs_in, rt_in, b_from_rt,
           hold, flush, wb_we, wb_rd, wb_data,
    output alu_out, wdMem_out, rd_out, WB_out, WMEM_out, load_out,
           extendForMem_out, zero_out, ovf_sticky
  );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register: operand forwarding, 16-bit ALU,
// hold/flush control and a sticky signed-overflow flag.
module ex_mem_stage #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 3
) (
  input logic           clk,
  input logic           rst_n,
  ex_mem_stage_if.slave bus
);
  localparam int unsigned MSB = DW - 1;
  localparam int unsigned SHW = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_PSB = 4'd10;
  localparam logic [3:0] OP_LUI = 4'd11;

  logic [DW-1:0] alu_q, alu_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          wb_q, wb_d;
  logic          wmem_q, wmem_d;
  logic          load_q, load_d;
  logic          ext_q, ext_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;

  logic          ex_fwd_ok;
  logic          wb_fwd_ok;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] st_data;
  logic [DW-1:0] sum;
  logic [DW-1:0] diff;
  logic [DW-1:0] result;
  logic          ovf;

  // Operand forwarding: EX/MEM (non-load) beats MEM/WB; r0 is never a target.
  always_comb begin
    ex_fwd_ok = wb_q & ~load_q & (rd_q != '0);
    wb_fwd_ok = bus.wb_we & (bus.wb_rd != '0);

    op_a = bus.R1_in;
    if (ex_fwd_ok && (rd_q == bus.rs_in))            op_a = alu_q;
    else if (wb_fwd_ok && (bus.wb_rd == bus.rs_in))  op_a = bus.wb_data;

    st_data = bus.wdMem_in;
    if (ex_fwd_ok && (rd_q == bus.rt_in))            st_data = alu_q;
    else if (wb_fwd_ok && (bus.wb_rd == bus.rt_in))  st_data = bus.wb_data;

    op_b = bus.b_from_rt ? st_data : bus.R2_in;
    if (bus.b_from_rt && !(ex_fwd_ok && (rd_q == bus.rt_in)) &&
        !(wb_fwd_ok && (bus.wb_rd == bus.rt_in)))
      op_b = bus.R2_in;
  end

  // ALU and signed overflow (ADD/SUB only)
  always_comb begin
    sum    = op_a + op_b;
    diff   = op_a - op_b;
    result = '0;
    ovf    = 1'b0;
    case (bus.aluSig_in)
      OP_ADD: begin
        result = sum;
        ovf    = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
      end
      OP_AND: result = op_a & op_b;
      OP_OR:  result = op_a | op_b;
      OP_XOR: result = op_a ^ op_b;
      OP_NOR: result = ~(op_a | op_b);
      OP_SLT: result = DW'($signed(op_a) < $signed(op_b));
      OP_SLL: result = op_a << op_b[SHW-1:0];
      OP_SRL: result = op_a >> op_b[SHW-1:0];
      OP_SRA: result = DW'($signed(op_a) >>> op_b[SHW-1:0]);
      OP_PSB: result = op_b;
      OP_LUI: result = DW'({op_b[7:0], 8'h00});
      default: result = '0;
    endcase
  end

  // Next state: hold freezes everything, flush bubbles the control bits.
  always_comb begin
    alu_d  = alu_q;
    wd_d   = wd_q;
    rd_d   = rd_q;
    wb_d   = wb_q;
    wmem_d = wmem_q;
    load_d = load_q;
    ext_d  = ext_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    if (!bus.hold) begin
      alu_d = result;
      wd_d  = st_data;
      rd_d  = bus.rd_in;
      ext_d = bus.extendForMem_in;
      if (bus.flush) begin
        wb_d   = 1'b0;
        wmem_d = 1'b0;
        load_d = 1'b0;
        zero_d = 1'b0;
      end else begin
        wb_d   = bus.WB_in;
        wmem_d = bus.WMEM_in;
        load_d = bus.load_in;
        zero_d = (result == '0);
        ovf_d  = ovf_q | ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q  <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
      wb_q   <= 1'b0;
      wmem_q <= 1'b0;
      load_q <= 1'b0;
      ext_q  <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      alu_q  <= alu_d;
      wd_q   <= wd_d;
      rd_q   <= rd_d;
      wb_q   <= wb_d;
      wmem_q <= wmem_d;
      load_q <= load_d;
      ext_q  <= ext_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.alu_out          = alu_q;
  assign bus.wdMem_out        = wd_q;
  assign bus.rd_out           = rd_q;
  assign bus.WB_out           = wb_q;
  assign bus.WMEM_out         = wmem_q;
  assign bus.load_out         = load_q;
  assign bus.extendForMem_out = ext_q;
  assign bus.zero_out         = zero_q;
  assign bus.ovf_sticky       = ovf_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: expected outputs are queued as each
// instruction is driven and popped after the capturing edge.
module tb_ex_mem_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_mem_stage_if #(.DW(16), .RW(3)) bus();
  ex_mem_stage #(.DW(16), .RW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] wd;
    logic [2:0]  rd;
    logic        wb;
    logic        wmem;
    logic        load;
    logic        ext;
    logic        zero;
    logic        ovf;
  } out_t;

  out_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic out_t mk(input logic [15:0] alu, input logic [15:0] wd,
                              input logic [2:0] rd, input logic wb, input logic wmem,
                              input logic ld, input logic ext, input logic zero,
                              input logic ovf);
    out_t e;
    e.alu = alu; e.wd = wd; e.rd = rd; e.wb = wb; e.wmem = wmem;
    e.load = ld; e.ext = ext; e.zero = zero; e.ovf = ovf;
    return e;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.alu = bus.alu_out; o.wd = bus.wdMem_out; o.rd = bus.rd_out;
    o.wb = bus.WB_out; o.wmem = bus.WMEM_out; o.load = bus.load_out;
    o.ext = bus.extendForMem_out; o.zero = bus.zero_out; o.ovf = bus.ovf_sticky;
    return o;
  endfunction

  function automatic out_t pop_exp();
    out_t e;
    if (sb.size() == 0) e = 'x;
    else e = sb.pop_front();
    return e;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [15:0] r1, input logic [15:0] r2,
                       input logic [15:0] wd, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic brt, input logic wb,
                       input logic wmem, input logic ld, input logic ext);
    bus.aluSig_in = op; bus.R1_in = r1; bus.R2_in = r2; bus.wdMem_in = wd;
    bus.rd_in = rd; bus.rs_in = rs; bus.rt_in = rt; bus.b_from_rt = brt;
    bus.WB_in = wb; bus.WMEM_in = wmem; bus.load_in = ld; bus.extendForMem_in = ext;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    out_t e, o;
    sb.push_back(mk(16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 0, 0));
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL reset: got %h want %h", o, e); end
  endtask

  task automatic test_add();
    out_t e, o;
    drive(4'd0, 16'h0003, 16'h0004, 16'h0, 3'd2, 3'd1, 3'd1, 0, 1, 0, 0, 0);
    sb.push_back(mk(16'h0007, 16'h0, 3'd2, 1, 0, 0, 0, 0, 0));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL add: got %h want %h", o, e); end
  endtask

  task automatic test_back_to_back();
    out_t e, o;
    drive(4'd0, 16'h0003, 16'h0004, 16'h0, 3'd2, 3'd1, 3'd1, 0, 1, 0, 0, 0);
    sb.push_back(mk(16'h0007, 16'h0, 3'd2, 1, 0, 0, 0, 0, 0));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL b2b_add: got %h want %h", o, e); end
    // SUB rs=2 with stale R1; A and store data forwarded from EX/MEM
    drive(4'd1, 16'h0000, 16'h0001, 16'h0, 3'd4, 3'd2, 3'd2, 0, 1, 0, 0, 0);
    sb.push_back(mk(16'h0006, 16'h0007, 3'd4, 1, 0, 0, 0, 0, 0));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL b2b_sub_fwd: got %h want %h", o, e); end
    // B forwarded by rt=4 from EX/MEM
    drive(4'd0, 16'h0010, 16'h0999, 16'h0, 3'd4, 3'd0, 3'd4, 1, 1, 0, 0, 0);
    sb.push_back(mk(16'h0016, 16'h0006, 3'd4, 1, 0, 0, 0, 0, 0));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL b2b_fwd_b: got %h want %h", o, e); end
  endtask

  task automatic test_alu_ops();
    out_t e, o;
    logic [15:0] tab [16];
    tab = '{16'h8434, 16'h840E, 16'h0001, 16'h8433, 16'h8432, 16'h7BCC, 16'h0001, 16'h2108,
            16'h1084, 16'hF084, 16'h0013, 16'h1300, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int op = 0; op < 16; op++) begin
      drive(4'(op), 16'h8421, 16'h0013, 16'h0, 3'd3, 3'd1, 3'd1, 0, 0, 0, 0, 0);
      sb.push_back(mk(tab[op], 16'h0, 3'd3, 0, 0, 0, 0, tab[op] == 16'h0, 0));
      step();
      e = pop_exp(); o = observe(); tests++;
      if (o !== e) begin fails++; $display("FAIL alu_op%0d: got %h want %h", op, o, e); end
    end
  endtask

  task automatic test_wb_forward();
    out_t e, o;
    bus.wb_we = 1'b1; bus.wb_rd = 3'd5; bus.wb_data = 16'h1234;
    drive(4'd0, 16'h0000, 16'h0000, 16'h0, 3'd6, 3'd5, 3'd1, 0, 1, 0, 0, 0);
    sb.push_back(mk(16'h1234, 16'h0, 3'd6, 1, 0, 0, 0, 0, 0));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL wb_fwd_a: got %h want %h", o, e); end
    drive(4'd10, 16'h0000, 16'h00AA, 16'h0, 3'd5, 3'd1, 3'd1, 0, 1, 0, 0, 0);
    sb.push_back(mk(16'h00AA, 16'h0, 3'd5, 1, 0, 0, 0, 0, 0));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL wb_set_r5: got %h want %h", o, e); end
    // both sources hold r5: EX/MEM wins
    drive(4'd0, 16'h0000, 16'h0000, 16'h0, 3'd7, 3'd5, 3'd1, 0, 1, 0, 0, 0);
    sb.push_back(mk(16'h00AA, 16'h0, 3'd7, 1, 0, 0, 0, 0, 0));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL wb_exmem_prio: got %h want %h", o, e); end
    drive(4'd0, 16'h0001, 16'h0000, 16'h0, 3'd7, 3'd0, 3'd5, 1, 1, 0, 0, 0);
    sb.push_back(mk(16'h1235, 16'h1234, 3'd7, 1, 0, 0, 0, 0, 0));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL wb_fwd_b: got %h want %h", o, e); end
    bus.wb_we = 1'b0;
  endtask

  task automatic test_r0_load();
    out_t e, o;
    drive(4'd10, 16'h0000, 16'h5555, 16'h0, 3'd0, 3'd1, 3'd1, 0, 1, 0, 0, 0);
    sb.push_back(mk(16'h5555, 16'h0, 3'd0, 1, 0, 0, 0, 0, 0));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL r0_write: got %h want %h", o, e); end
    bus.wb_we = 1'b1; bus.wb_rd = 3'd0; bus.wb_data = 16'hFFFF;
    drive(4'd0, 16'h0000, 16'h0000, 16'h0, 3'd2, 3'd0, 3'd0, 1, 1, 0, 0, 0);
    sb.push_back(mk(16'h0000, 16'h0, 3'd2, 1, 0, 0, 0, 1, 0));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL r0_no_fwd: got %h want %h", o, e); end
    bus.wb_we = 1'b0;
    drive(4'd0, 16'h0100, 16'h0004, 16'h0, 3'd3, 3'd1, 3'd1, 0, 1, 0, 1, 1);
    sb.push_back(mk(16'h0104, 16'h0, 3'd3, 1, 0, 1, 1, 0, 0));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL load_issue: got %h want %h", o, e); end
    // load in EX/MEM must not forward to rs or rt
    drive(4'd0, 16'h0050, 16'h0000, 16'h0077, 3'd2, 3'd3, 3'd3, 0, 1, 0, 0, 0);
    sb.push_back(mk(16'h0050, 16'h0077, 3'd2, 1, 0, 0, 0, 0, 0));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL load_no_fwd: got %h want %h", o, e); end
  endtask

  task automatic test_hold_flush();
    out_t e, o, st;
    st = mk(16'h0208, 16'hBEEF, 3'd0, 0, 1, 0, 0, 0, 0);
    drive(4'd0, 16'h0200, 16'h0008, 16'hBEEF, 3'd0, 3'd1, 3'd1, 0, 0, 1, 0, 0);
    sb.push_back(st);
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL store: got %h want %h", o, e); end
    // overflowing ADD offered while held must not set the sticky flag
    bus.hold = 1'b1;
    drive(4'd0, 16'h7FFF, 16'h0001, 16'h0, 3'd2, 3'd1, 3'd1, 0, 1, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      sb.push_back(st);
      step();
      e = pop_exp(); o = observe(); tests++;
      if (o !== e) begin fails++; $display("FAIL hold%0d: got %h want %h", c, o, e); end
    end
    bus.flush = 1'b1;
    sb.push_back(st);
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL hold_flush: got %h want %h", o, e); end
    bus.hold = 1'b0;
    drive(4'd0, 16'h7FFF, 16'h0001, 16'h0, 3'd2, 3'd1, 3'd1, 0, 1, 1, 1, 0);
    sb.push_back(mk(16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 0, 0));
    step();
    e = pop_exp(); o = observe(); tests++;
    if ({o.wb, o.wmem, o.load, o.zero, o.ovf} !== {e.wb, e.wmem, e.load, e.zero, e.ovf}) begin
      fails++; $display("FAIL flush_ctrl: got %h want %h", o, e);
    end
    bus.flush = 1'b0;
  endtask

  task automatic test_overflow();
    out_t e, o;
    drive(4'd0, 16'h7FFF, 16'h0001, 16'h0, 3'd2, 3'd1, 3'd1, 0, 0, 0, 0, 0);
    sb.push_back(mk(16'h8000, 16'h0, 3'd2, 0, 0, 0, 0, 0, 1));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL ovf_add: got %h want %h", o, e); end
    drive(4'd2, 16'hFFFF, 16'h0F0F, 16'h0, 3'd2, 3'd1, 3'd1, 0, 0, 0, 0, 0);
    sb.push_back(mk(16'h0F0F, 16'h0, 3'd2, 0, 0, 0, 0, 0, 1));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL ovf_sticky: got %h want %h", o, e); end
  endtask

  task automatic test_async_reset();
    out_t e, o;
    rst_n = 1'b0;
    #2;
    sb.push_back(mk(16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 0, 0));
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL async_reset: got %h want %h", o, e); end
    #1 rst_n = 1'b1;
    drive(4'd0, 16'h0001, 16'h0001, 16'h0, 3'd2, 3'd1, 3'd1, 0, 1, 0, 0, 0);
    sb.push_back(mk(16'h0002, 16'h0, 3'd2, 1, 0, 0, 0, 0, 0));
    step();
    e = pop_exp(); o = observe(); tests++;
    if (o !== e) begin fails++; $display("FAIL post_reset: got %h want %h", o, e); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.hold = 1'b0; bus.flush = 1'b0;
    bus.wb_we = 1'b0; bus.wb_rd = 3'd0; bus.wb_data = 16'h0;
    drive(4'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_add();
    test_back_to_back();
    test_alu_ops();
    test_wb_forward();
    test_r0_load();
    test_hold_flush();
    test_overflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
